// File: rtl/clock_irq_timer.sv
// clock_irq_timer: 64-bit machine timer (mtime/mtimecmp) with a sticky pending bit.
// It drives the clock interrupt line.
// The bus is memory-mapped: single-cycle writes, and read data is registered one cycle after bus_re.
// Optional feature: define TIMER_AUTORELOAD_EN to enable the PERIOD register.
// When enabled, mtimecmp reloads automatically on every compare hit.
// PRESC_W must be 16 or less, because the prescaler lives in CTRL[31:16].
module clock_irq_timer #(
   parameter int          PRESC_W = 16,
   parameter logic [63:0] RST_CMP = 64'hFFFF_FFFF_FFFF_FFFF
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        bus_we,
   input  logic        bus_re,
   input  logic [4:0]  bus_addr,
   input  logic [31:0] bus_wdata,
   output logic [31:0] bus_rdata,
   output logic        irq_clock,
   output logic [63:0] mtime_o
);

   localparam logic [2:0] IDX_MTIME_LO = 3'd0;
   localparam logic [2:0] IDX_MTIME_HI = 3'd1;
   localparam logic [2:0] IDX_CMP_LO   = 3'd2;
   localparam logic [2:0] IDX_CMP_HI   = 3'd3;
   localparam logic [2:0] IDX_CTRL     = 3'd4;
   localparam logic [2:0] IDX_STATUS   = 3'd5;
   localparam logic [2:0] IDX_PERIOD   = 3'd6;

   logic [2:0]         word_idx;
   logic               unused_addr_bits;
   logic [63:0]        mtime;
   logic [63:0]        mtimecmp;
   logic [PRESC_W-1:0] presc;
   logic [PRESC_W-1:0] presc_cnt;
   logic               en;
   logic               ie;
   logic               pending;
   logic               hit;
   logic               hit_q;
   logic               new_hit;
   logic               clear_req;
   logic               set_fire;
   logic               tick;
   logic               wr_mtime_lo;
   logic               wr_mtime_hi;
   logic               wr_cmp_lo;
   logic               wr_cmp_hi;
   logic               wr_ctrl;
   logic               wr_status;
   logic [31:0]        period_rd;
   logic [31:0]        rd_mux;
`ifdef TIMER_AUTORELOAD_EN
   logic               wr_period;
   logic [31:0]        period;
   logic               reload;
`endif

   // The low address bits select bytes within a word and carry no meaning here.
   assign word_idx         = bus_addr[4:2];
   assign unused_addr_bits = ^bus_addr[1:0];

   assign wr_mtime_lo = bus_we && (word_idx == IDX_MTIME_LO);
   assign wr_mtime_hi = bus_we && (word_idx == IDX_MTIME_HI);
   assign wr_cmp_lo   = bus_we && (word_idx == IDX_CMP_LO);
   assign wr_cmp_hi   = bus_we && (word_idx == IDX_CMP_HI);
   assign wr_ctrl     = bus_we && (word_idx == IDX_CTRL);
   assign wr_status   = bus_we && (word_idx == IDX_STATUS);

   // The compare uses registered values only, so pending follows a hit by exactly one edge.
   // A software clear is honoured unless the hit has only just appeared; in that case the set wins.
   // With a steady hit, a clear therefore drops pending for one cycle and it then re-asserts.
   assign hit       = (mtime >= mtimecmp);
   assign new_hit   = hit && !hit_q;
   assign clear_req = (wr_status && bus_wdata[0]) || wr_cmp_lo || wr_cmp_hi;
   assign set_fire  = hit && !(clear_req && !new_hit);

   // The counter compares with >= so that shrinking presc mid-count wraps at once.
   // With == it would run all the way round the counter instead.
   assign tick = en && (presc_cnt >= presc);

   assign irq_clock = pending && ie;
   assign mtime_o   = mtime;

`ifdef TIMER_AUTORELOAD_EN
   assign wr_period = bus_we && (word_idx == IDX_PERIOD);
   assign reload    = set_fire && (period != 32'd0);
   assign period_rd = period;
`else
   assign period_rd = 32'd0;
`endif

   // Prescaler counts 0..presc while enabled and freezes when disabled.
   always_ff @(posedge clk) begin
      if (!clr) begin
         presc_cnt <= '0;
      end else if (en) begin
         if (tick) presc_cnt <= '0;
         else      presc_cnt <= presc_cnt + PRESC_W'(1);
      end
   end

   // mtime: a bus write to either half beats the tick, and the other half holds with no carry.
   always_ff @(posedge clk) begin
      if (!clr) begin
         mtime <= 64'd0;
      end else if (wr_mtime_lo) begin
         mtime <= {mtime[63:32], bus_wdata};
      end else if (wr_mtime_hi) begin
         mtime <= {bus_wdata, mtime[31:0]};
      end else if (tick) begin
         mtime <= mtime + 64'd1;
      end
   end

   // mtimecmp: software writes take precedence over the optional automatic reload.
   always_ff @(posedge clk) begin
      if (!clr) begin
         mtimecmp <= RST_CMP;
      end else if (wr_cmp_lo) begin
         mtimecmp <= {mtimecmp[63:32], bus_wdata};
      end else if (wr_cmp_hi) begin
         mtimecmp <= {bus_wdata, mtimecmp[31:0]};
`ifdef TIMER_AUTORELOAD_EN
      end else if (reload) begin
         mtimecmp <= mtimecmp + {32'd0, period};
`endif
      end
   end

   // CTRL register holds enable, interrupt enable and the prescaler value.
   always_ff @(posedge clk) begin
      if (!clr) begin
         en    <= 1'b0;
         ie    <= 1'b0;
         presc <= '0;
      end else if (wr_ctrl) begin
         en    <= bus_wdata[0];
         ie    <= bus_wdata[1];
         presc <= bus_wdata[16 +: PRESC_W];
      end
   end

`ifdef TIMER_AUTORELOAD_EN
   // PERIOD register holds the amount added to mtimecmp on every hit.
   always_ff @(posedge clk) begin
      if (!clr)           period <= 32'd0;
      else if (wr_period) period <= bus_wdata;
   end
`endif

   // Sticky pending bit, plus a one-cycle-old copy of hit used to spot fresh hits.
   always_ff @(posedge clk) begin
      if (!clr) begin
         pending <= 1'b0;
         hit_q   <= 1'b0;
      end else begin
         hit_q <= hit;
         if (set_fire)       pending <= 1'b0 | 1'b1;
         else if (clear_req) pending <= 1'b0;
      end
   end

   // Read mux: it sees pre-write state, so a read and write to the same word returns the old value.
   always_comb begin
      rd_mux = 32'd0;
      case (word_idx)
         IDX_MTIME_LO: rd_mux = mtime[31:0];
         IDX_MTIME_HI: rd_mux = mtime[63:32];
         IDX_CMP_LO:   rd_mux = mtimecmp[31:0];
         IDX_CMP_HI:   rd_mux = mtimecmp[63:32];
         IDX_CTRL:     rd_mux = {16'(presc), 14'd0, ie, en};
         IDX_STATUS:   rd_mux = {31'd0, pending};
         IDX_PERIOD:   rd_mux = period_rd;
         default:      rd_mux = 32'd0;
      endcase
   end

   // Registered read data: updates on bus_re and otherwise holds the last value.
   always_ff @(posedge clk) begin
      if (!clr)        bus_rdata <= 32'd0;
      else if (bus_re) bus_rdata <= rd_mux;
   end

endmodule
